period_timer_ctrl: RTL
======================

PERIOD_TIMER_CTRL -- requirements
Module: period_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the period and count.
REQ-002 SHALL have parameter PSC_W, default 4, giving the width of the prescale value.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to arm the timer; sampled on a clk edge.
REQ-006 SHALL have port stop, input, 1 bit: abort request; sampled on a clk edge.
REQ-007 SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = periodic; latched on an accepted start.
REQ-008 SHALL have port period, input, WIDTH bits: terminal tick count; latched on an accepted start.
REQ-009 SHALL have port prescale, input, PSC_W bits: a tick occurs every prescale+1 clk cycles; latched on an accepted start.
REQ-010 SHALL have port tick, output, 1 bit: enable strobe for the downstream counter.
REQ-011 SHALL have port count, output, WIDTH bits: current tick count.
REQ-012 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when count reaches period.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-015 SHALL implement the FSM states IDLE and RUN, with done and err held as registered pulses.
REQ-016 In IDLE, with start=1, stop=0 and period!=0, SHALL latch mode, period and prescale, clear count and psc, and enter RUN on the same edge; busy is therefore high from the cycle after that edge.
REQ-017 In IDLE, with start=1 and period==0, SHALL stay in IDLE and pulse err for exactly one cycle.
REQ-018 In IDLE, if start and stop are high together, SHALL let stop win: stay in IDLE, no err.
REQ-019 SHALL compute tick combinationally as busy AND (psc == latched prescale); psc is an internal PSC_W-bit counter.
REQ-020 On a tick edge, SHALL clear psc; otherwise, while in RUN, SHALL increment psc.
REQ-021 On a tick edge with count != period-1, SHALL set count to count+1.
REQ-022 On a tick edge with count == period-1, SHALL set count to 0 and register done=1 for one cycle.
REQ-023 After the terminal tick in one-shot mode, SHALL go to IDLE, so busy falls in the same cycle that done rises.
REQ-024 After the terminal tick in periodic mode, SHALL stay in RUN and wrap count with no idle cycle.
REQ-025 In RUN, SHALL ignore start and leave the latched values unchanged.
REQ-026 In RUN, stop SHALL take priority over tick: go to IDLE, clear count and psc, no done pulse.
REQ-027 SHALL keep count unsigned and wrap-free, since it is bounded by period-1.
REQ-028 SHALL hold count in IDLE.
REQ-029 SHALL never assert done and err in the same cycle.

Reset
REQ-030 While rst=0, SHALL asynchronously force: state=IDLE, count=0, psc=0, latched registers=0, done=0, err=0; tick and busy are therefore 0.
REQ-031 SHALL treat reset asserted mid-RUN as an abort: no done pulse, and the timer returns to operation only on a fresh start after release.

Structure
REQ-032 SHALL place the state encoding (IDLE, RUN) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1) in shared package timer_pkg.
REQ-033 SHALL implement psc and the tick compare in a sub-module named tick_prescaler (ports clk, rst, run, clr, prescale, tick).

Verification
REQ-034 Bench SHALL check one-shot: period=4, prescale=0, start at edge E0 -> busy high during E0..E4, tick on each of 4 cycles, count 1,2,3,0, done high for one cycle after E4, busy low after E4.
REQ-035 Bench SHALL check prescale: period=3, prescale=1, one-shot -> tick every 2nd cycle, busy high for 6 cycles, exactly one done.
REQ-036 Bench SHALL check periodic: period=2, prescale=0, run 10 cycles -> done pulses every 2 cycles, busy held high, count toggles 1,0.
REQ-037 Bench SHALL check stop: stop asserted together with the terminal tick -> no done, IDLE, count=0; start with stop in IDLE -> stays IDLE.
REQ-038 Bench SHALL check period=0 start -> one err pulse, busy stays 0; start during RUN -> no effect on count or the latched period.
REQ-039 Bench SHALL check async reset: rst low between clock edges mid-RUN -> all outputs 0 immediately; after release, idle until the next start.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: FSM state encoding and mode constants shared by the period timer.
package timer_pkg;
    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_RUN        = 1'b1;
    localparam logic       MODE_ONESHOT  = 1'b0;
    localparam logic       MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts clk cycles while running and strobes tick when the count equals prescale.
module tick_prescaler #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);
    logic [PSC_W-1:0] psc_q, psc_d;

    assign tick = run && (psc_q == prescale);

    always_comb begin
        psc_d = (clr || tick) ? '0 : run ? PSC_W'(psc_q + 1'b1) : psc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) psc_q <= '0;
        else      psc_q <= psc_d;
    end
endmodule

// File: rtl/period_timer_ctrl.sv
// period_timer_ctrl: one-shot/periodic tick timer with prescaler, stop abort and
// registered done/err pulses.
module period_timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);
    logic [0:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [PSC_W-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             psc_clr;
    logic             last_tick;

    assign busy      = (state_q == ST_RUN);
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;
    assign last_tick = (count_q == period_q - WIDTH'(1));

    tick_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk      (clk),
        .rst      (rst),
        .run      (busy),
        .clr      (psc_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // stop beats start in IDLE and beats tick in RUN, so an abort never emits done
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        psc_clr    = 1'b0;
        if (!busy) begin
            if (start && !stop) begin
                if (period == '0) begin
                    err_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    mode_d     = mode;
                    period_d   = period;
                    prescale_d = prescale;
                    count_d    = '0;
                    psc_clr    = 1'b1;
                end
            end
        end else if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            psc_clr = 1'b1;
        end else if (tick) begin
            count_d = last_tick ? '0 : WIDTH'(count_q + 1'b1);
            done_d  = last_tick;
            state_d = (last_tick && mode_q == MODE_ONESHOT) ? ST_IDLE : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_ONESHOT;
            period_q   <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule
